conv_encoder: RTL and testbench
===============================

# conv_encoder

Rate-1/2 convolutional encoder with optional puncturing to 2/3 or 3/4 and zero-tail frame termination. It is the transmit-side counterpart of `viterbi_dec`. Per input bit it emits a 2-bit code symbol plus a 2-bit validity mask, and that pair drives `viterbi_dec` `i_data`/`i_valid` directly: punctured positions carry mask bit 0. Frames are started by a command and counted. Ready/valid backpressure applies on both sides.

## Interface
- p_size_polinom, 3, constraint length K (≥2)
- p_polinom_0, 3'b111, generator for o_data[0]
- p_polinom_1, 3'b101, generator for o_data[1]
- p_defoult_state, 3'b000, encoder register value loaded at frame start
- p_len_w, 16, width of frame length
- i_clk  in  1  clock; one clock domain
- i_reset  in  1  synchronous, active-high reset
- i_start  in  1  frame start command; sampled only in IDLE
- i_frame_len  in  p_len_w  number of data bits in the frame; sampled with i_start
- i_rate  in  2  0: 1/2, 1: 2/3, 2: 3/4, 3: treated as 1/2; sampled with i_start
- i_data  in  1  data bit
- i_valid  in  1  data bit valid
- o_ready  out  1  encoder accepts i_data this cycle
- o_data  out  2  code symbol {g1, g0}
- o_valid  out  2  per-bit valid mask; nonzero = symbol present
- i_ready  in  1  downstream accepts the current symbol
- o_last  out  1  marks the final tail symbol of a frame
- o_busy  out  1  high from the cycle after an accepted i_start until the return to IDLE

## Operation
- FSM states: IDLE, DATA, TAIL.
- IDLE → DATA on i_start when i_frame_len≠0. IDLE → TAIL on i_start when i_frame_len=0. On the start transition: r_state ← p_defoult_state, counters cleared, rate latched.
- Encoding: w_next = {r_state[K-2:0], b}, newest bit at the LSB. g0 = ^(w_next & p_polinom_0), g1 = ^(w_next & p_polinom_1). r_state ← w_next.
- Output register is one slot. It is "empty" when o_valid=00. It is freed when it is full and i_ready=1.
- DATA: o_ready = slot empty, or i_ready=1. Each transfer (i_valid & o_ready) encodes one bit and loads the slot, with o_valid = puncture mask. After i_frame_len accepted bits → TAIL.
- TAIL: K-1 zero bits are encoded. Each one is loaded when the slot is free. Tail symbols are never punctured (mask 11). o_last=1 on the final tail symbol.
- After the o_last symbol is taken → IDLE. o_busy falls in the same cycle as the transition.
- Puncture masks use a period counter that is cleared at frame start and advances per data bit. Masks are given as index 0, 1, 2.
  - Rate 1/2: 11.
  - Rate 2/3: 11, 01.
  - Rate 3/4: 11, 01, 10.
- i_start while o_busy=1 is ignored. i_valid outside DATA is ignored, and o_ready=0 there.
- i_reset in any state, including mid-frame: FSM → IDLE, slot emptied, r_state ← p_defoult_state. The partial frame is dropped.

## Timing
- Reset values: o_data=00, o_valid=00, o_ready=0, o_last=0, o_busy=0.
- Frame start: i_start accepted in cycle 0 → DATA in cycle 1, with o_ready=1 in cycle 1.
- Latency: a bit accepted in cycle t appears on o_data/o_valid in cycle t+1.
- Without stalls, throughput is 1 symbol/cycle. A frame of N bits occupies N+K-1 output cycles.
- Outputs are registered. o_data, o_valid and o_last hold stable while o_valid≠00 and i_ready=0.
- Simultaneous free-and-load is allowed. When the slot is taken and a new bit arrives in the same cycle, the slot is reloaded with no bubble.
- The last data transfer and the first tail load may occur in consecutive cycles.

## Structure
- Shared package/include `conv_pkg`:
  - rate codes RATE_1_2, RATE_2_3, RATE_3_4;
  - FSM state encodings;
  - puncture mask constants;
  - function `conv_sym(state, bit, poly0, poly1)`. `viterbi_dec` is later refactored onto the same function.
- One sub-module, `conv_puncture`: the period counter plus mask lookup. It has inputs clear, advance, rate, tail and output mask[1:0].

## Test plan
- Rate 1/2, K=3, polys 111/101, N=4, data 1,0,1,1, i_ready=1:
  - o_data = 11, 01, 00, 10, 10, 11;
  - o_valid = 11 on all six symbols;
  - o_last only on the 6th symbol.
- Same data at rate 3/4:
  - o_valid = 11, 01, 10, 11, 11, 11;
  - o_data as in the rate-1/2 case (masked bits are don't-care).
- Rate 1/2, i_ready=0 for 2 cycles while the 2nd symbol (01) is presented: o_data holds 01, o_ready=0, and no input bit is consumed. After release, the sequence continues unchanged.
- i_frame_len=0, i_start: two symbols 00/00 with o_valid=11, o_last on the 2nd. o_busy drops when the 2nd symbol is taken.
- i_reset asserted after 2 of 4 bits: next cycle o_valid=00, o_busy=0, IDLE. A fresh frame with data 1,0,1,1 reproduces the first scenario exactly.
- Loopback: random 256-bit frames at each rate into `viterbi_dec`, error-free channel → decoded bits equal the transmitted bits.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the convolutional encoder and its matching decoder.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package conv_pkg;

   // Widest constraint length the shared symbol helper supports.
   localparam int CONV_K_MAX = 8;

   // Code rate selection; any other code falls back to rate 1/2.
   typedef enum logic [1:0] {
      RATE_1_2 = 2'd0,
      RATE_2_3 = 2'd1,
      RATE_3_4 = 2'd2
   } conv_rate_t;

   // Frame sequencing states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_TAIL = 2'd2
   } conv_state_t;

   // Per-symbol validity masks, bit0 = g0, bit1 = g1.
   localparam logic [1:0] MASK_BOTH = 2'b11;
   localparam logic [1:0] MASK_G0   = 2'b01;
   localparam logic [1:0] MASK_G1   = 2'b10;

   // Code symbol {g1, g0} produced when bit_in is shifted into state.
   // Polynomials are zero-extended, so state bits above K-1 never contribute.
   function automatic logic [1:0] conv_sym(
      input logic [CONV_K_MAX-1:0] state,
      input logic                  bit_in,
      input logic [CONV_K_MAX-1:0] poly0,
      input logic [CONV_K_MAX-1:0] poly1
   );
      logic [CONV_K_MAX-1:0] w;
      w = {state[CONV_K_MAX-2:0], bit_in};
      return {^(w & poly1), ^(w & poly0)};
   endfunction

endpackage

// File: rtl/conv_puncture.sv
// Puncture period counter and mask lookup for the convolutional encoder.
// Latency: mask is combinational from the registered phase; phase steps 1 cycle after advance.
// Backpressure: none; the parent only pulses advance on an accepted data bit.
module conv_puncture
   import conv_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_clear,
   input  logic       i_advance,
   input  logic [1:0] i_rate,
   input  logic       i_tail,
   output logic [1:0] o_mask
);

   logic [1:0] r_phase;
   logic [1:0] w_last_phase;

   // Highest phase index of the puncture period for the latched rate.
   always_comb begin
      w_last_phase = 2'd0;
      case (i_rate)
         RATE_2_3: w_last_phase = 2'd1;
         RATE_3_4: w_last_phase = 2'd2;
         default:  w_last_phase = 2'd0;
      endcase
   end

   // Phase counter: cleared at frame start, wraps at the end of each period.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_phase <= 2'd0;
      end else if (i_clear) begin
         r_phase <= 2'd0;
      end else if (i_advance) begin
         r_phase <= (r_phase == w_last_phase) ? 2'd0 : r_phase + 2'd1;
      end
   end

   // Mask lookup; the phase never reaches an index its rate does not define,
   // so one table serves all rates. Tail symbols always carry both bits.
   always_comb begin
      o_mask = MASK_BOTH;
      if (!i_tail) begin
         case (r_phase)
            2'd1:    o_mask = MASK_G0;
            2'd2:    o_mask = MASK_G1;
            default: o_mask = MASK_BOTH;
         endcase
      end
   end

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2 convolutional encoder with 2/3, 3/4 puncturing and zero-tail termination.
// Latency: a bit accepted in cycle t is presented on o_data/o_valid in cycle t+1.
// Backpressure: one-slot output register; o_ready = slot empty or i_ready, held symbols stay stable.
module conv_encoder
   import conv_pkg::*;
#(
   parameter int                      p_size_polinom  = 3,
   parameter logic [p_size_polinom-1:0] p_polinom_0     = 3'b111,
   parameter logic [p_size_polinom-1:0] p_polinom_1     = 3'b101,
   parameter logic [p_size_polinom-1:0] p_defoult_state = 3'b000,
   parameter int                      p_len_w         = 16
)(
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_start,
   input  logic [p_len_w-1:0] i_frame_len,
   input  logic [1:0]         i_rate,
   input  logic               i_data,
   input  logic               i_valid,
   output logic               o_ready,
   output logic [1:0]         o_data,
   output logic [1:0]         o_valid,
   input  logic               i_ready,
   output logic               o_last,
   output logic               o_busy
);

   localparam int K  = p_size_polinom;
   localparam int TW = $clog2(K) + 1;

   conv_state_t        r_fsm;
   logic [K-1:0]       r_state;
   logic [1:0]         r_rate;
   logic [p_len_w-1:0] r_len;
   logic [p_len_w-1:0] r_bit_cnt;
   logic [TW-1:0]      r_tail_cnt;
   logic [1:0]         r_data;
   logic [1:0]         r_valid;
   logic               r_last;
   logic               r_busy;

   logic               w_slot_empty;
   logic               w_slot_taken;
   logic               w_slot_free;
   logic               w_start;
   logic               w_data_take;
   logic               w_tail_pend;
   logic               w_tail_load;
   logic               w_load;
   logic               w_bit;
   logic [K-1:0]       w_next;
   logic [1:0]         w_sym;
   logic [1:0]         w_mask;

   // Slot handshake: the slot can accept a new symbol when it is empty or
   // is being drained this very cycle, which gives back-to-back symbols.
   assign w_slot_empty = (r_valid == 2'b00);
   assign w_slot_taken = !w_slot_empty && i_ready;
   assign w_slot_free  = w_slot_empty || i_ready;

   assign w_start     = (r_fsm == ST_IDLE) && i_start;
   assign w_data_take = (r_fsm == ST_DATA) && i_valid && w_slot_free;
   assign w_tail_pend = (r_tail_cnt < TW'(K - 1));
   assign w_tail_load = (r_fsm == ST_TAIL) && w_tail_pend && w_slot_free;
   assign w_load      = w_data_take || w_tail_load;

   // Tail bits are zeros that flush the shift register back to all-zero.
   assign w_bit  = w_data_take ? i_data : 1'b0;
   assign w_next = {r_state[K-2:0], w_bit};
   assign w_sym  = conv_sym(CONV_K_MAX'(r_state), w_bit,
                            CONV_K_MAX'(p_polinom_0), CONV_K_MAX'(p_polinom_1));

   conv_puncture u_puncture (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_clear   (w_start),
      .i_advance (w_data_take),
      .i_rate    (r_rate),
      .i_tail    (r_fsm == ST_TAIL),
      .o_mask    (w_mask)
   );

   assign o_ready = (r_fsm == ST_DATA) && w_slot_free;
   assign o_data  = r_data;
   assign o_valid = r_valid;
   assign o_last  = r_last;
   assign o_busy  = r_busy;

   // Frame FSM, encoder shift register and the registered output slot.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_fsm      <= ST_IDLE;
         r_state    <= p_defoult_state;
         r_rate     <= RATE_1_2;
         r_len      <= '0;
         r_bit_cnt  <= '0;
         r_tail_cnt <= '0;
         r_data     <= 2'b00;
         r_valid    <= 2'b00;
         r_last     <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         // Drain first; a load in the same cycle overrides the drain.
         if (w_slot_taken) begin
            r_valid <= 2'b00;
            r_last  <= 1'b0;
         end
         if (w_load) begin
            r_data  <= w_sym;
            r_valid <= w_mask;
            r_last  <= w_tail_load && (r_tail_cnt == TW'(K - 2));
            r_state <= w_next;
         end

         case (r_fsm)
            ST_IDLE: begin
               if (i_start) begin
                  r_state    <= p_defoult_state;
                  r_bit_cnt  <= '0;
                  r_tail_cnt <= '0;
                  r_rate     <= i_rate;
                  r_len      <= i_frame_len;
                  r_busy     <= 1'b1;
                  r_fsm      <= (i_frame_len == '0) ? ST_TAIL : ST_DATA;
               end
            end
            ST_DATA: begin
               if (w_data_take) begin
                  r_bit_cnt <= r_bit_cnt + 1'b1;
                  if (r_bit_cnt == r_len - 1'b1) begin
                     r_fsm <= ST_TAIL;
                  end
               end
            end
            ST_TAIL: begin
               if (w_tail_load) begin
                  r_tail_cnt <= r_tail_cnt + 1'b1;
               end
               // Frame ends when the marked final symbol leaves the slot.
               if (w_slot_taken && r_last) begin
                  r_fsm  <= ST_IDLE;
                  r_busy <= 1'b0;
               end
            end
            default: begin
               r_fsm <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_conv_encoder.sv
// Self-checking bench for conv_encoder: directed scenarios plus random frames
// compared symbol-by-symbol against an arithmetic reference model.
module tb_conv_encoder;

   localparam int K  = 3;
   localparam int P0 = 7;
   localparam int P1 = 5;

   logic        clk = 1'b0;
   logic        i_reset, i_start, i_data, i_valid, i_ready;
   logic [15:0] i_frame_len;
   logic [1:0]  i_rate;
   logic        o_ready, o_last, o_busy;
   logic [1:0]  o_data, o_valid;

   always #5 clk = ~clk;

   conv_encoder dut (
      .i_clk       (clk),
      .i_reset     (i_reset),
      .i_start     (i_start),
      .i_frame_len (i_frame_len),
      .i_rate      (i_rate),
      .i_data      (i_data),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .o_data      (o_data),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_last      (o_last),
      .o_busy      (o_busy)
   );

   typedef struct packed {
      logic [1:0] d;
      logic [1:0] m;
      logic       l;
   } sym_t;

   sym_t model_q[$];
   sym_t exp_q[$];
   sym_t obs_q[$];
   sym_t mon_cur;
   bit   frame_bits [256];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   rdy_mode = 0;   // 0: always ready, 1: random, 2: driven by a scenario
   bit   chk_idle = 1'b0;

   int lit_d [6];
   int lit_m [6];
   int lit_l [6];

   task automatic check(input string name, input int act, input int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Puncture mask for data bit i at a given rate code.
   function automatic int mask_of(input int rate, input int i);
      int per;
      per = (rate == 1) ? 2 : (rate == 2) ? 3 : 1;
      case (i % per)
         0:       return 3;
         1:       return 1;
         default: return 2;
      endcase
   endfunction

   // Reference: expected symbol stream for frame_bits[0..n-1] plus K-1 zero tail bits.
   task automatic model_frame(input int n, input int rate);
      int   s, w, b;
      sym_t e;
      model_q.delete();
      s = 0;
      for (int i = 0; i < n + K - 1; i++) begin
         b = (i < n) ? int'(frame_bits[i]) : 0;
         w = ((s << 1) | b) & ((1 << K) - 1);
         s = w;
         e.d[1] = ($countones(w & P1) % 2) == 1;
         e.d[0] = ($countones(w & P0) % 2) == 1;
         e.m    = (i >= n) ? 2'b11 : 2'(mask_of(rate, i));
         e.l    = (i == n + K - 2);
         model_q.push_back(e);
      end
   endtask

   // Output monitor: every presented symbol is compared to the head of the
   // expected queue; it is consumed only when the bench is ready.
   always @(negedge clk) begin
      if (chk_idle) begin
         check("busy_drop_after_last", int'(o_busy), 0);
         chk_idle = 1'b0;
      end
      if (!i_reset && o_valid != 2'b00) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_symbol: got data %b valid %b, required no symbol", o_data, o_valid);
         end else begin
            mon_cur = exp_q[0];
            check("sym_valid", int'(o_valid), int'(mon_cur.m));
            check("sym_data", int'(o_data & mon_cur.m), int'(mon_cur.d & mon_cur.m));
            check("sym_last", int'(o_last), int'(mon_cur.l));
            check("busy_during_frame", int'(o_busy), 1);
            if (i_ready) begin
               void'(exp_q.pop_front());
               obs_q.push_back(sym_t'({o_data & o_valid, o_valid, o_last}));
               if (mon_cur.l) chk_idle = 1'b1;
            end
         end
      end
   end

   // Downstream ready generator.
   always @(posedge clk) begin
      #1;
      if (rdy_mode == 0) i_ready = 1'b1;
      else if (rdy_mode == 1) i_ready = ($urandom_range(2) != 0);
   end

   task automatic run_frame(input int n, input int rate, input int dens, input bit spam);
      int idx, cyc;
      bit first;
      model_frame(n, rate);
      foreach (model_q[i]) exp_q.push_back(model_q[i]);
      obs_q.delete();
      @(posedge clk); #1;
      i_start = 1'b1; i_frame_len = 16'(n); i_rate = 2'(rate);
      @(posedge clk); #1;
      i_start = spam;
      idx = 0; cyc = 0; first = 1'b1;
      while (idx < n && cyc < 4000) begin
         i_valid = ($urandom_range(99) < dens);
         i_data  = frame_bits[idx];
         @(negedge clk);
         if (first) begin
            check("ready_cycle1", int'(o_ready), 1);
            check("busy_cycle1", int'(o_busy), 1);
            first = 1'b0;
         end
         if (i_valid && o_ready) idx++;
         @(posedge clk); #1;
         cyc++;
      end
      i_valid = 1'b0;
      i_start = 1'b0;
      check("data_accepted", idx, n);
      while (o_busy && cyc < 8000) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("frame_done_in_time", int'(o_busy), 0);
      check("exp_drained", exp_q.size(), 0);
      check("obs_count", obs_q.size(), n + K - 1);
   endtask

   task automatic check_obs(input string name, input int d[6], input int m[6], input int l[6], input int cnt);
      for (int i = 0; i < cnt; i++) begin
         check({name, "_data"},  (obs_q.size() > i) ? int'(obs_q[i].d) : -1, d[i] & m[i]);
         check({name, "_valid"}, (obs_q.size() > i) ? int'(obs_q[i].m) : -1, m[i]);
         check({name, "_last"},  (obs_q.size() > i) ? int'(obs_q[i].l) : -1, l[i]);
      end
   endtask

   // Holds i_ready low for two cycles while the symbol 01 is presented.
   task automatic stall_watch();
      int cyc;
      cyc = 0;
      while (!(o_valid != 2'b00 && o_data == 2'b01) && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("stall_symbol_seen", int'(cyc < 20), 1);
      i_ready = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("stall_hold_data", int'(o_data), 1);
         check("stall_ready_low", int'(o_ready), 0);
         @(posedge clk); #1;
      end
      i_ready = 1'b1;
   endtask

   task automatic set_1011();
      frame_bits[0] = 1'b1; frame_bits[1] = 1'b0;
      frame_bits[2] = 1'b1; frame_bits[3] = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      int idx, cyc;
      i_reset = 1'b1; i_start = 1'b0; i_frame_len = '0; i_rate = 2'd0;
      i_data = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
      lit_d = '{3, 1, 0, 2, 2, 3};
      lit_l = '{0, 0, 0, 0, 0, 1};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_o_data",  int'(o_data), 0);
      check("reset_o_valid", int'(o_valid), 0);
      check("reset_o_ready", int'(o_ready), 0);
      check("reset_o_last",  int'(o_last), 0);
      check("reset_o_busy",  int'(o_busy), 0);
      @(posedge clk); #1;
      i_reset = 1'b0;

      // Pin the reference model against hand-derived symbols.
      set_1011();
      model_frame(4, 0);
      for (int i = 0; i < 6; i++) check("model_data_r12", int'(model_q[i].d), lit_d[i]);
      model_frame(4, 2);
      lit_m = '{3, 1, 2, 3, 3, 3};
      for (int i = 0; i < 6; i++) check("model_mask_r34", int'(model_q[i].m), lit_m[i]);

      // Rate 1/2, always ready.
      rdy_mode = 0;
      lit_m = '{3, 3, 3, 3, 3, 3};
      run_frame(4, 0, 100, 1'b0);
      check_obs("r12", lit_d, lit_m, lit_l, 6);

      // Rate 3/4, same data.
      lit_m = '{3, 1, 2, 3, 3, 3};
      run_frame(4, 2, 100, 1'b0);
      check_obs("r34", lit_d, lit_m, lit_l, 6);

      // Rate 1/2 with a two-cycle stall on the second symbol.
      rdy_mode = 2;
      i_ready  = 1'b1;
      lit_m = '{3, 3, 3, 3, 3, 3};
      fork
         run_frame(4, 0, 100, 1'b0);
         stall_watch();
      join
      check_obs("stall", lit_d, lit_m, lit_l, 6);
      rdy_mode = 0;

      // Empty frame: only the zero tail.
      lit_d = '{0, 0, 0, 0, 0, 0};
      lit_l = '{0, 1, 0, 0, 0, 0};
      run_frame(0, 0, 100, 1'b0);
      check_obs("len0", lit_d, lit_m, lit_l, 2);

      // Data outside a frame is refused.
      @(posedge clk); #1;
      i_valid = 1'b1;
      @(negedge clk);
      check("idle_ready_low", int'(o_ready), 0);
      @(posedge clk); #1;
      i_valid = 1'b0;
      @(negedge clk);
      check("idle_no_symbol", int'(o_valid), 0);

      // Reset after two of four bits, then a clean frame.
      set_1011();
      model_frame(4, 0);
      foreach (model_q[i]) exp_q.push_back(model_q[i]);
      @(posedge clk); #1;
      i_start = 1'b1; i_frame_len = 16'd4; i_rate = 2'd0;
      @(posedge clk); #1;
      i_start = 1'b0;
      idx = 0; cyc = 0;
      while (idx < 2 && cyc < 20) begin
         i_valid = 1'b1;
         i_data  = frame_bits[idx];
         @(negedge clk);
         if (o_ready) idx++;
         @(posedge clk); #1;
         cyc++;
      end
      i_valid = 1'b0;
      i_reset = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      i_reset = 1'b0;
      @(negedge clk);
      check("midreset_o_valid", int'(o_valid), 0);
      check("midreset_o_busy",  int'(o_busy), 0);
      check("midreset_o_ready", int'(o_ready), 0);
      lit_d = '{3, 1, 0, 2, 2, 3};
      lit_l = '{0, 0, 0, 0, 0, 1};
      run_frame(4, 0, 100, 1'b0);
      check_obs("after_reset", lit_d, lit_m, lit_l, 6);

      // Random 256-bit frames at every rate code with random flow control,
      // with i_start held high during the frame to confirm it is ignored.
      rdy_mode = 1;
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 256; i++) frame_bits[i] = bit'($urandom_range(1));
         run_frame(256, r, 75, 1'b1);
      end
      // Short random frames, including the single-bit boundary.
      for (int f = 0; f < 4; f++) begin
         for (int i = 0; i < 8; i++) frame_bits[i] = bit'($urandom_range(1));
         run_frame((f == 0) ? 1 : int'($urandom_range(7, 1)), int'($urandom_range(3)), 60, 1'b0);
      end
      rdy_mode = 0;
      repeat (3) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
